// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit for the HI/LO path.
// Shift-add multiply (LSB first) and restoring divide (MSB first), one bit
// per clock, followed by a single sign-correction cycle. MTHI/MTLO write
// HI/LO directly in one cycle.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [5:0]       Signal,
    input  logic [WIDTH-1:0] dataA,
    input  logic [WIDTH-1:0] dataB,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done
);

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]      CNT_LOAD = CW'(WIDTH - 1);
    localparam logic [CW-1:0]      CNT_ONE  = CW'(1);
    localparam logic [CW-1:0]      CNT_ZERO = {CW{1'b0}};
    localparam logic [WIDTH-1:0]   ZERO_W   = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0]   ONES_W   = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0]   ONE_W    = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [2*WIDTH-1:0] ONE_2W   = {{(2*WIDTH-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_t;

    // Two's complement magnitude of v when it is a signed negative value.
    function automatic logic [WIDTH-1:0] abs_val(input logic [WIDTH-1:0] v, input logic sgn);
        abs_val = (sgn && v[WIDTH-1]) ? (~v + ONE_W) : v;
    endfunction

    state_t             state_r;
    logic [CW-1:0]      cnt_r;
    logic [2*WIDTH-1:0] acc_r;     // product accumulator, or quotient in low half
    logic [WIDTH-1:0]   rem_r;     // partial remainder
    logic [WIDTH-1:0]   opnd_r;    // multiplicand or divisor magnitude
    logic               div_r;
    logic               signed_r;
    logic               neg_a_r;
    logic               neg_b_r;
    logic               dz_r;

    logic               op_mul_s;
    logic               op_div_s;
    logic               op_signed_s;
    logic [WIDTH-1:0]   a_abs_s;
    logic [WIDTH-1:0]   b_abs_s;
    logic [WIDTH:0]     mul_sum_s;
    logic [2*WIDTH-1:0] mul_next_s;
    logic [WIDTH:0]     div_shift_s;
    logic               div_ge_s;
    logic [WIDTH-1:0]   div_rem_next_s;
    logic [WIDTH-1:0]   div_q_next_s;
    logic               sign_diff_s;
    logic [2*WIDTH-1:0] prod_fix_s;
    logic [WIDTH-1:0]   quot_fix_s;
    logic [WIDTH-1:0]   rem_fix_s;
    logic [WIDTH-1:0]   fix_hi_s;
    logic [WIDTH-1:0]   fix_lo_s;

    // Decode the requested operation and form operand magnitudes.
    always_comb begin
        op_mul_s    = (Signal == OP_MULT) || (Signal == OP_MULTU);
        op_div_s    = (Signal == OP_DIV)  || (Signal == OP_DIVU);
        op_signed_s = (Signal == OP_MULT) || (Signal == OP_DIV);
        a_abs_s     = abs_val(dataA, op_signed_s);
        b_abs_s     = abs_val(dataB, op_signed_s);
    end

    // One iteration of shift-add multiply and restoring divide.
    always_comb begin
        mul_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]} + {1'b0, (acc_r[0] ? opnd_r : ZERO_W)};
        mul_next_s  = {mul_sum_s, acc_r[WIDTH-1:1]};
        div_shift_s = {rem_r, acc_r[WIDTH-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        // The true difference is below the divisor, so W-bit wraparound is exact.
        div_rem_next_s = div_ge_s ? (div_shift_s[WIDTH-1:0] - opnd_r) : div_shift_s[WIDTH-1:0];
        div_q_next_s   = {acc_r[WIDTH-2:0], div_ge_s};
    end

    // Sign correction and divide-by-zero override applied in the FIX cycle.
    always_comb begin
        sign_diff_s = signed_r && (neg_a_r ^ neg_b_r);
        prod_fix_s  = sign_diff_s ? (~acc_r + ONE_2W) : acc_r;
        if (dz_r) begin
            quot_fix_s = ONES_W;
        end else if (sign_diff_s) begin
            quot_fix_s = ~acc_r[WIDTH-1:0] + ONE_W;
        end else begin
            quot_fix_s = acc_r[WIDTH-1:0];
        end
        // Remainder follows the dividend's sign; with a zero divisor this restores dataA.
        rem_fix_s = (signed_r && neg_a_r) ? (~rem_r + ONE_W) : rem_r;
        fix_hi_s  = div_r ? rem_fix_s  : prod_fix_s[2*WIDTH-1:WIDTH];
        fix_lo_s  = div_r ? quot_fix_s : prod_fix_s[WIDTH-1:0];
    end

    // Control FSM, datapath registers and registered HI/LO/busy/done.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= ST_IDLE;
            cnt_r    <= CNT_ZERO;
            acc_r    <= {ZERO_W, ZERO_W};
            rem_r    <= ZERO_W;
            opnd_r   <= ZERO_W;
            div_r    <= 1'b0;
            signed_r <= 1'b0;
            neg_a_r  <= 1'b0;
            neg_b_r  <= 1'b0;
            dz_r     <= 1'b0;
            hi       <= ZERO_W;
            lo       <= ZERO_W;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (start && (op_mul_s || op_div_s)) begin
                        div_r    <= op_div_s;
                        signed_r <= op_signed_s;
                        neg_a_r  <= op_signed_s && dataA[WIDTH-1];
                        neg_b_r  <= op_signed_s && dataB[WIDTH-1];
                        dz_r     <= op_div_s && (dataB == ZERO_W);
                        acc_r    <= op_div_s ? {ZERO_W, a_abs_s} : {ZERO_W, b_abs_s};
                        opnd_r   <= op_div_s ? b_abs_s : a_abs_s;
                        rem_r    <= ZERO_W;
                        cnt_r    <= CNT_LOAD;
                        busy     <= 1'b1;
                        state_r  <= ST_RUN;
                    end else if (start && (Signal == OP_MTHI)) begin
                        hi <= dataA;
                    end else if (start && (Signal == OP_MTLO)) begin
                        lo <= dataA;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (div_r) begin
                        acc_r <= {ZERO_W, div_q_next_s};
                        rem_r <= div_rem_next_s;
                    end else begin
                        acc_r <= mul_next_s;
                    end
                    cnt_r <= cnt_r - CNT_ONE;
                    if (cnt_r == CNT_ZERO) begin
                        state_r <= ST_FIX;
                    end else begin
                        state_r <= ST_RUN;
                    end
                end
                ST_FIX: begin
                    hi      <= fix_hi_s;
                    lo      <= fix_lo_s;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
                default: begin
                    busy    <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit at WIDTH 8, 16 and 32 against an
// arithmetic reference model with a cycle-by-cycle compare process.
module tb_muldiv_unit;

    localparam logic [5:0] OP_MULT  = 6'b011000;
    localparam logic [5:0] OP_MULTU = 6'b011001;
    localparam logic [5:0] OP_DIV   = 6'b011010;
    localparam logic [5:0] OP_DIVU  = 6'b011011;
    localparam logic [5:0] OP_MTHI  = 6'b010001;
    localparam logic [5:0] OP_MTLO  = 6'b010011;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [5:0]  op_s = 6'd0;
    logic [31:0] a_s = 32'd0;
    logic [31:0] b_s = 32'd0;
    int          sel = 2;
    logic        chk_en = 1'b0;

    logic [7:0]  hi8, lo8;
    logic [15:0] hi16, lo16;
    logic [31:0] hi32, lo32;
    logic        busy8, busy16, busy32, done8, done16, done32;
    logic        start8, start16, start32;
    logic [31:0] hi_d, lo_d;
    logic        busy_d, done_d;

    int n_pass = 0;
    int n_total = 0;

    // model state
    logic [31:0] exp_hi, exp_lo;
    logic        exp_busy, exp_done;
    logic [63:0] pend;
    int          remain = 0;

    assign start8  = start && (sel == 0);
    assign start16 = start && (sel == 1);
    assign start32 = start && (sel == 2);

    muldiv_unit #(.WIDTH(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .Signal(op_s),
        .dataA(a_s[7:0]), .dataB(b_s[7:0]),
        .hi(hi8), .lo(lo8), .busy(busy8), .done(done8));

    muldiv_unit #(.WIDTH(16)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start16), .Signal(op_s),
        .dataA(a_s[15:0]), .dataB(b_s[15:0]),
        .hi(hi16), .lo(lo16), .busy(busy16), .done(done16));

    muldiv_unit #(.WIDTH(32)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start32), .Signal(op_s),
        .dataA(a_s), .dataB(b_s),
        .hi(hi32), .lo(lo32), .busy(busy32), .done(done32));

    always #5 clk = ~clk;

    // Route the selected instance's outputs to the common compare path.
    always_comb begin
        if (sel == 0) begin
            hi_d = {24'h0, hi8};  lo_d = {24'h0, lo8};  busy_d = busy8;  done_d = done8;
        end else if (sel == 1) begin
            hi_d = {16'h0, hi16}; lo_d = {16'h0, lo16}; busy_d = busy16; done_d = done16;
        end else begin
            hi_d = hi32;          lo_d = lo32;          busy_d = busy32; done_d = done32;
        end
    end

    function automatic int wof(input int s);
        return (s == 0) ? 8 : ((s == 1) ? 16 : 32);
    endfunction

    function automatic logic [31:0] wmask(input int w);
        logic [63:0] m;
        m = (64'd1 << w) - 64'd1;
        return m[31:0];
    endfunction

    function automatic logic is_iter(input logic [5:0] op);
        return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    // Reference arithmetic: returns {hi, lo} for a w-bit operation.
    function automatic logic [63:0] ref_op(input logic [5:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input int w);
        logic [63:0] mask, ua, ub, p, h, l;
        longint sa, sb, q, r;
        mask = (64'd1 << w) - 64'd1;
        ua = {32'h0, a} & mask;
        ub = {32'h0, b} & mask;
        sa = ua[w-1] ? (longint'(ua) - (longint'(1) << w)) : longint'(ua);
        sb = ub[w-1] ? (longint'(ub) - (longint'(1) << w)) : longint'(ub);
        h = 64'd0;
        l = 64'd0;
        case (op)
            OP_MULTU: begin p = ua * ub; h = (p >> w) & mask; l = p & mask; end
            OP_MULT:  begin p = 64'(sa * sb); h = (p >> w) & mask; l = p & mask; end
            OP_DIVU: begin
                if (ub == 64'd0) begin l = mask; h = ua; end
                else begin l = ua / ub; h = ua % ub; end
            end
            OP_DIV: begin
                if (ub == 64'd0) begin l = mask; h = ua; end
                else begin q = sa / sb; r = sa % sb; l = 64'(q) & mask; h = 64'(r) & mask; end
            end
            default: begin h = 64'd0; l = 64'd0; end
        endcase
        return {h[31:0], l[31:0]};
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t sel=%0d)", name, act, exp, $time, sel);
    endtask

    // Behavioural model: tracks what HI/LO/busy/done must be after each edge.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_hi = 32'd0; exp_lo = 32'd0; exp_busy = 1'b0; exp_done = 1'b0; remain = 0;
        end else begin
            exp_done = 1'b0;
            if (remain > 0) begin
                remain--;
                if (remain == 0) begin
                    exp_hi = pend[63:32]; exp_lo = pend[31:0];
                    exp_done = 1'b1; exp_busy = 1'b0;
                end
            end else if (start) begin
                if (is_iter(op_s)) begin
                    pend = ref_op(op_s, a_s, b_s, wof(sel));
                    remain = wof(sel) + 1;
                    exp_busy = 1'b1;
                end else if (op_s == OP_MTHI) begin
                    exp_hi = a_s & wmask(wof(sel));
                end else if (op_s == OP_MTLO) begin
                    exp_lo = a_s & wmask(wof(sel));
                end
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("hi",   {32'h0, hi_d},          {32'h0, exp_hi});
            chk("lo",   {32'h0, lo_d},          {32'h0, exp_lo});
            chk("busy", {63'h0, busy_d},        {63'h0, exp_busy});
            chk("done", {63'h0, done_d},        {63'h0, exp_done});
        end
    end

    task automatic reset_to(input int s);
        @(negedge clk);
        rst_n = 1'b0;
        sel = s;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_hi", {32'h0, hi_d}, 64'd0);
        chk("rst_lo", {32'h0, lo_d}, 64'd0);
        chk("rst_busy", {63'h0, busy_d}, 64'd0);
        chk("rst_done", {63'h0, done_d}, 64'd0);
    endtask

    // Issue one op at the current negedge; returns at the negedge where the
    // result is visible. inject>0 pulses a DIVU start that many cycles in.
    task automatic do_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input int inject);
        int w, lat, bc;
        w = wof(sel);
        start = 1'b1; op_s = op; a_s = a; b_s = b;
        @(negedge clk);
        start = 1'b0;
        a_s = $urandom; b_s = $urandom;
        if (is_iter(op)) begin
            lat = 0;
            bc = 0;
            while (!done_d && lat < 4 * w) begin
                if (busy_d) bc++;
                if (inject != 0 && lat == inject) begin
                    start = 1'b1; op_s = OP_DIVU; b_s = 32'd3;
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
                lat++;
            end
            start = 1'b0;
            chk("latency", 64'(lat), 64'(w + 1));
            chk("busy_cycles", 64'(bc), 64'(w + 1));
        end
    endtask

    function automatic logic [31:0] rand_val(input int w);
        int r;
        r = $urandom_range(0, 9);
        case (r)
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'd1 << (w - 1);
            3: return 32'd1;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0] op_tab [9];
        op_tab = '{OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO,
                   6'b000000, 6'b111111, 6'b010000};

        #3 rst_n = 1'b0;
        #4 chk_en = 1'b1;
        reset_to(2);

        // literal pins on the model itself
        chk("pin_multu", ref_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32), 64'hFFFFFFFE_00000001);
        chk("pin_mult",  ref_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 32), 64'hFFFFFFFF_FFFFFFEB);
        chk("pin_div",   ref_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 32), 64'hFFFFFFFF_FFFFFFFD);
        chk("pin_divz",  ref_op(OP_DIVU, 32'd100, 32'd0, 32), 64'h00000064_FFFFFFFF);
        chk("pin_ovf",   ref_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32), 64'h00000000_80000000);
        chk("pin_mult8", ref_op(OP_MULT, 32'h80, 32'h80, 8), 64'h00000040_00000000);

        // directed operations with hand-computed results
        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        chk("multu_hi", {32'h0, hi_d}, 64'hFFFF_FFFE);
        chk("multu_lo", {32'h0, lo_d}, 64'h0000_0001);
        do_op(OP_MULT, 32'hFFFF_FFF9, 32'd3, 0);
        chk("mult_hi", {32'h0, hi_d}, 64'hFFFF_FFFF);
        chk("mult_lo", {32'h0, lo_d}, 64'hFFFF_FFEB);
        do_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
        chk("div_hi", {32'h0, hi_d}, 64'hFFFF_FFFF);
        chk("div_lo", {32'h0, lo_d}, 64'hFFFF_FFFD);
        do_op(OP_DIVU, 32'd100, 32'd0, 0);
        chk("divz_hi", {32'h0, hi_d}, 64'd100);
        chk("divz_lo", {32'h0, lo_d}, 64'hFFFF_FFFF);
        do_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        chk("ovf_hi", {32'h0, hi_d}, 64'd0);
        chk("ovf_lo", {32'h0, lo_d}, 64'h8000_0000);

        // start while busy is ignored; MTHI in the done cycle
        do_op(OP_MULTU, 32'h0001_0000, 32'h0001_0001, 10);
        chk("ign_hi", {32'h0, hi_d}, 64'h0000_0001);
        chk("ign_lo", {32'h0, lo_d}, 64'h0001_0000);
        do_op(OP_MTHI, 32'h0000_1234, 32'd0, 0);
        chk("mthi_hi", {32'h0, hi_d}, 64'h0000_1234);
        chk("mthi_lo", {32'h0, lo_d}, 64'h0001_0000);

        // asynchronous reset in the middle of RUN
        start = 1'b1; op_s = OP_MULTU; a_s = 32'hDEAD_BEEF; b_s = 32'h1234_5678;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_hi", {32'h0, hi_d}, 64'd0);
        chk("arst_lo", {32'h0, lo_d}, 64'd0);
        chk("arst_busy", {63'h0, busy_d}, 64'd0);
        chk("arst_done", {63'h0, done_d}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(OP_MULTU, 32'd6, 32'd7, 0);
        chk("post_hi", {32'h0, hi_d}, 64'd0);
        chk("post_lo", {32'h0, lo_d}, 64'd42);

        // randomized sweep over all three widths
        for (int s = 0; s < 3; s++) begin
            reset_to(s);
            for (int i = 0; i < 30; i++) begin
                do_op(op_tab[$urandom_range(0, 8)], rand_val(wof(s)), rand_val(wof(s)), 0);
            end
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative integer multiply/divide unit for the pipelined CPU's HI/LO path, generalised to a parametrised WIDTH. It supports signed and unsigned multiply and divide plus direct HI/LO writes. It accepts one operation at a time through a start/busy/done handshake and computes one bit per clock. It holds the result in internal HI/LO registers until the next operation overwrites them. The control unit stalls HI/LO readers while `busy` is high.

## Interface
- `WIDTH`, 32: operand width; HI and LO are each WIDTH bits.
- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `start`  in  1  request; sampled only when `busy`=0.
- `Signal`  in  6  operation code (MIPS funct): MULT 011000, MULTU 011001, DIV 011010, DIVU 011011, MTHI 010001, MTLO 010011.
- `dataA`  in  WIDTH  multiplicand / dividend / MTHI-MTLO source.
- `dataB`  in  WIDTH  multiplier / divisor.
- `hi`  out  WIDTH  HI register: product upper half or remainder.
- `lo`  out  WIDTH  LO register: product lower half or quotient.
- `busy`  out  1  an iterative operation is in progress.
- `done`  out  1  single-cycle pulse; `hi`/`lo` updated this cycle.

## Operation
- Reset (`rst_n`=0, any time including mid-operation): `hi`=0, `lo`=0, `busy`=0, `done`=0, FSM to IDLE. The partial result is discarded.
- States: IDLE, RUN, FIX.
- IDLE, `start`=1, op MULT/MULTU/DIV/DIVU:
  - Latch operands, operation and signedness.
  - For signed ops, latch absolute values and record the sign flags.
  - Load iteration counter with WIDTH-1; go to RUN; set `busy`=1.
- IDLE, `start`=1, op MTHI/MTLO: `hi` (resp. `lo`) <= `dataA` at that edge. No busy, no done.
- IDLE, `start`=1, any other code: ignored. No state change.
- `start` while `busy`=1: ignored; never queued.
- RUN, multiply: shift-add, one multiplier bit per cycle, LSB first, into a 2*WIDTH accumulator.
- RUN, divide: restoring division, one quotient bit per cycle, MSB first, into a WIDTH+1-bit partial remainder.
- Counter decrements each RUN cycle. Go to FIX after the cycle in which the counter is 0, i.e. exactly WIDTH RUN cycles.
- FIX, sign correction:
  - Signed multiply: negate the 2*WIDTH product if the operand signs differ.
  - Signed divide: quotient negated if the signs differ; remainder takes the dividend's sign.
  - Write `hi`/`lo`, pulse `done`, clear `busy`, return to IDLE.
- Arithmetic rules:
  - Product is the full 2*WIDTH bits, with no truncation: `hi`=bits [2W-1:W], `lo`=bits [W-1:0].
  - Unsigned ops treat operands as unsigned; signed ops as two's complement.
- Divide by zero (`dataB`=0): full latency still taken. Result is `lo`=all ones, `hi`=`dataA` (unmodified dividend), for both DIV and DIVU.
- Signed overflow (DIV, `dataA`=most negative, `dataB`=-1): `lo`=most negative value, `hi`=0. Wraps, no trap.
- `hi`/`lo` hold their previous values throughout RUN. They change only at the FIX edge, on MTHI/MTLO, or on reset.

## Timing
- `start` accepted at edge k: `busy`=1 after edge k, through edge k+WIDTH.
- FIX occupies the cycle after edge k+WIDTH. At edge k+WIDTH+1:
  - `hi`/`lo` take the result.
  - `done`=1 for exactly that one cycle.
  - `busy`=0.
- Latency from the accepting edge to the result: WIDTH+1 cycles, i.e. 33 for WIDTH=32.
- A new `start` may be accepted in the same cycle `done` is high. Back-to-back throughput is one op per WIDTH+1 cycles.
- `dataA`/`dataB`/`Signal` need be valid only at the accepting edge.
- MTHI/MTLO latency is 1 cycle: the value is visible after the accepting edge.
- `done` never asserts without a preceding accepted iterative op. The `done` reset value is 0.

## Test plan
- Reset, then MULTU WIDTH=32, A=0xFFFFFFFF, B=0xFFFFFFFF -> after 33 cycles `hi`=0xFFFFFFFE, `lo`=0x00000001; `done` high for one cycle; `busy` high for 33 cycles.
- MULT A=-7 (0xFFFFFFF9), B=3 -> `hi`=0xFFFFFFFF, `lo`=0xFFFFFFEB. DIV A=-7, B=2 -> `lo`=0xFFFFFFFD (-3), `hi`=0xFFFFFFFF (-1).
- DIVU A=100, B=0 -> `lo`=0xFFFFFFFF, `hi`=100. DIV A=0x80000000, B=0xFFFFFFFF -> `lo`=0x80000000, `hi`=0.
- MULTU in progress; pulse `start` with DIVU at cycle 10 -> ignored, MULTU result unchanged. Then MTHI A=0x1234 issued in the `done` cycle -> `hi`=0x1234 next cycle, `lo` unchanged.
- Assert `rst_n`=0 asynchronously mid-RUN (cycle 15) -> `busy`, `done`, `hi`, `lo` all 0 immediately. After release, a fresh MULTU 6*7 gives `lo`=42, `hi`=0.
- Parameter sweep WIDTH=8 and WIDTH=16 with random signed/unsigned ops checked against a reference model. Latency must be exactly WIDTH+1 in each case.
